// File: rtl/hack_cpu_mc_if.sv
// Instruction-fetch and data-memory req/ack bundle for hack_cpu_mc.
// The master modport is the core side; the slave modport is the memory side.
interface hack_cpu_mc_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_data;
    logic              dmem_rd;
    logic              dmem_wr;
    logic [ADDR_W-1:0] dmem_addr;
    logic [WIDTH-1:0]  dmem_wdata;
    logic              dmem_ack;
    logic [WIDTH-1:0]  dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with req/ack instruction and data memory ports.
// Define HACK_CPU_HALT_EN to stop the core on a taken jump-to-self.
//
// state  | meaning
// IDLE   | first cycle after reset
// FETCH  | instruction request outstanding
// MEM_RD | M operand read outstanding
// EXEC   | ALU, register write-back, next pc
// MEM_WR | M write outstanding
// HALT   | stopped until reset (HACK_CPU_HALT_EN only)
module hack_cpu_mc #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    hack_cpu_mc_if.master     bus,
    output logic [ADDR_W-1:0] pc,
    output logic [WIDTH-1:0]  a_reg,
    output logic [WIDTH-1:0]  d_reg,
    output logic              retired,
    output logic              halted
);

`ifdef HACK_CPU_HALT_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MEM_RD, S_EXEC, S_MEM_WR, S_HALT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MEM_RD, S_EXEC, S_MEM_WR} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [15:0]       ir_q, ir_d;
    logic              retired_q, retired_d;
`ifdef HACK_CPU_HALT_EN
    logic              halt_pend_q, halt_pend_d;
`endif

    logic [WIDTH-1:0]  alu_x, alu_y, alu_f, alu_out;
    logic              alu_zr, alu_ng, jump_taken;

    // Hack ALU: comp bits are zx nx zy ny f no at IR[11:6]
    always_comb begin
        alu_x = ir_q[11] ? '0 : d_q;
        if (ir_q[10]) alu_x = ~alu_x;
        alu_y = ir_q[9] ? '0 : (ir_q[12] ? m_q : a_q);
        if (ir_q[8]) alu_y = ~alu_y;
        alu_f   = ir_q[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        alu_out = ir_q[6] ? ~alu_f : alu_f;
    end

    assign alu_zr     = (alu_out == '0);
    assign alu_ng     = alu_out[WIDTH-1];
    assign jump_taken = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        d_d       = d_q;
        m_d       = m_q;
        ir_d      = ir_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        retired_d = 1'b0;
`ifdef HACK_CPU_HALT_EN
        halt_pend_d = halt_pend_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_data;
                    state_d = (bus.imem_data[15] && bus.imem_data[12]) ? S_MEM_RD : S_EXEC;
                end
            end
            S_MEM_RD: begin
                if (bus.dmem_ack) begin
                    m_d     = bus.dmem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!ir_q[15]) begin
                    a_d       = {{(WIDTH-15){1'b0}}, ir_q[14:0]};
                    pc_d      = pc_q + 1'b1;
                    retired_d = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    // write address and jump target both come from the pre-instruction A
                    if (ir_q[5]) a_d = alu_out;
                    if (ir_q[4]) d_d = alu_out;
                    wr_addr_d = a_q[ADDR_W-1:0];
                    wr_data_d = alu_out;
                    pc_d      = jump_taken ? a_q[ADDR_W-1:0] : pc_q + 1'b1;
                    retired_d = ~ir_q[3];
`ifdef HACK_CPU_HALT_EN
                    halt_pend_d = jump_taken && (a_q[ADDR_W-1:0] == pc_q);
                    if (ir_q[3])          state_d = S_MEM_WR;
                    else if (halt_pend_d) state_d = S_HALT;
                    else                  state_d = S_FETCH;
`else
                    state_d = ir_q[3] ? S_MEM_WR : S_FETCH;
`endif
                end
            end
            S_MEM_WR: begin
                if (bus.dmem_ack) begin
                    retired_d = 1'b1;
`ifdef HACK_CPU_HALT_EN
                    state_d = halt_pend_q ? S_HALT : S_FETCH;
`else
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef HACK_CPU_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            a_q       <= '0;
            d_q       <= '0;
            m_q       <= '0;
            ir_q      <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            retired_q <= 1'b0;
`ifdef HACK_CPU_HALT_EN
            halt_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            a_q       <= a_d;
            d_q       <= d_d;
            m_q       <= m_d;
            ir_q      <= ir_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            retired_q <= retired_d;
`ifdef HACK_CPU_HALT_EN
            halt_pend_q <= halt_pend_d;
`endif
        end
    end

    assign bus.imem_req   = (state_q == S_FETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_rd    = (state_q == S_MEM_RD);
    assign bus.dmem_wr    = (state_q == S_MEM_WR);
    assign bus.dmem_addr  = (state_q == S_MEM_RD) ? a_q[ADDR_W-1:0] : wr_addr_q;
    assign bus.dmem_wdata = wr_data_q;

    assign pc      = pc_q;
    assign a_reg   = a_q;
    assign d_reg   = d_q;
    assign retired = retired_q;
`ifdef HACK_CPU_HALT_EN
    assign halted  = (state_q == S_HALT);
`else
    assign halted  = 1'b0;
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: wait-stated ROM/RAM responders plus an instruction-level
// reference interpreter checked at every retired pulse.
module tb_hack_cpu_mc;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 15;
    localparam int RAM_N  = 2 ** ADDR_W;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  d;
    } wr_t;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic [WIDTH-1:0]  a_reg, d_reg;
    logic              retired, halted;

    hack_cpu_mc_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    hack_cpu_mc #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pc      (pc),
        .a_reg   (a_reg),
        .d_reg   (d_reg),
        .retired (retired),
        .halted  (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]      rom     [256];
    logic [WIDTH-1:0] mem_ram [RAM_N];
    logic [WIDTH-1:0] m_ram   [RAM_N];

    logic [ADDR_W-1:0] m_pc;
    logic [WIDTH-1:0]  m_a, m_d;
    bit                m_halted;
    int                n_ret;
    int                ret_cyc[$];
    wr_t               wq[$];
    logic [ADDR_W-1:0] rq[$];

    int  cyc, first_req;
    int  i_fixed, d_fixed;
    bit  spur, chk_en;
    int  n_chk, n_bad;

    bit                i_busy, d_busy;
    int                i_cnt, d_cnt;
    logic [ADDR_W-1:0] i_addr0, d_addr0;
    logic [WIDTH-1:0]  d_wd0;

    logic [5:0] comps [18] = '{6'h2A, 6'h3F, 6'h3A, 6'h0C, 6'h30, 6'h0D, 6'h31, 6'h0F, 6'h33,
                               6'h1F, 6'h37, 6'h0E, 6'h32, 6'h02, 6'h13, 6'h07, 6'h00, 6'h15};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Mnemonic-level meaning of each Hack comp code; y is A or M
    function automatic logic [WIDTH-1:0] alu_ref(input logic [5:0] c, input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        case (c)
            6'h2A:   return ZERO;
            6'h3F:   return ONE;
            6'h3A:   return ZERO - ONE;
            6'h0C:   return x;
            6'h30:   return y;
            6'h0D:   return ~x;
            6'h31:   return ~y;
            6'h0F:   return ZERO - x;
            6'h33:   return ZERO - y;
            6'h1F:   return x + ONE;
            6'h37:   return y + ONE;
            6'h0E:   return x - ONE;
            6'h32:   return y - ONE;
            6'h02:   return x + y;
            6'h13:   return x - y;
            6'h07:   return y - x;
            6'h00:   return x & y;
            6'h15:   return x | y;
            default: return 'x;
        endcase
    endfunction

    function automatic int pick(input int f);
        return (f >= 0) ? f : int'($urandom_range(0, 3));
    endfunction

    function automatic logic [15:0] rand_ins();
        logic [14:0] v;
        logic [5:0]  c;
        logic [2:0]  j;
        if ($urandom_range(0, 2) == 0) begin
            v = ($urandom_range(0, 9) == 0) ? 15'($urandom) : 15'($urandom_range(0, 255));
            return {1'b0, v};
        end
        c = comps[$urandom_range(0, 17)];
        j = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        return {3'b111, 1'($urandom), c, 3'($urandom), j};
    endfunction

    task automatic model_step();
        logic [15:0]      ins;
        logic [WIDTH-1:0] y, res, old_a;
        logic             taken;
        wr_t              w;
        ins   = rom[m_pc[7:0]];
        old_a = m_a;
        if (!ins[15]) begin
            m_a  = {{(WIDTH-15){1'b0}}, ins[14:0]};
            m_pc = m_pc + 1'b1;
        end else begin
            if (ins[12]) begin
                chk("rd_seen", 64'(rq.size()), 64'd1);
                if (rq.size() > 0) chk("rd_addr", rq.pop_front(), old_a[ADDR_W-1:0]);
                y = m_ram[old_a[ADDR_W-1:0]];
            end else begin
                y = old_a;
            end
            res   = alu_ref(ins[11:6], m_d, y);
            taken = (ins[2] && $signed(res) < 0) || (ins[1] && res == ZERO) ||
                    (ins[0] && $signed(res) > 0);
            if (ins[3]) begin
                m_ram[old_a[ADDR_W-1:0]] = res;
                chk("wr_seen", 64'(wq.size()), 64'd1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    chk("wr_addr", w.a, old_a[ADDR_W-1:0]);
                    chk("wr_data", w.d, res);
                end
            end
            if (ins[5]) m_a = res;
            if (ins[4]) m_d = res;
`ifdef HACK_CPU_HALT_EN
            if (taken && old_a[ADDR_W-1:0] == m_pc) m_halted = 1'b1;
`endif
            m_pc = taken ? old_a[ADDR_W-1:0] : m_pc + 1'b1;
        end
        chk("pc", pc, m_pc);
        chk("a_reg", a_reg, m_a);
        chk("d_reg", d_reg, m_d);
    endtask

    // Memory responders and retire-time checker, all sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                i_busy = 1'b0;
                d_busy = 1'b0;
                bus.imem_ack = 1'b0;
                bus.dmem_ack = 1'b0;
            end else begin
                if (bus.imem_req && first_req < 0) first_req = cyc;
                if (bus.imem_req) begin
                    if (!i_busy) begin
                        i_busy  = 1'b1;
                        i_cnt   = pick(i_fixed);
                        i_addr0 = bus.imem_addr;
                    end else begin
                        chk("imem_addr_hold", bus.imem_addr, i_addr0);
                    end
                    if (i_cnt == 0) begin
                        bus.imem_ack  = 1'b1;
                        bus.imem_data = rom[bus.imem_addr[7:0]];
                        i_busy        = 1'b0;
                    end else begin
                        bus.imem_ack  = 1'b0;
                        bus.imem_data = 16'($urandom);
                        i_cnt--;
                    end
                end else begin
                    i_busy        = 1'b0;
                    bus.imem_ack  = spur && ($urandom_range(0, 3) == 0);
                    bus.imem_data = 16'($urandom);
                end

                chk("dmem_rd_wr_excl", 64'(bus.dmem_rd & bus.dmem_wr), 64'd0);
                if (bus.dmem_rd || bus.dmem_wr) begin
                    if (!d_busy) begin
                        d_busy  = 1'b1;
                        d_cnt   = pick(d_fixed);
                        d_addr0 = bus.dmem_addr;
                        d_wd0   = bus.dmem_wdata;
                    end else begin
                        chk("dmem_addr_hold", bus.dmem_addr, d_addr0);
                        if (bus.dmem_wr) chk("dmem_wdata_hold", bus.dmem_wdata, d_wd0);
                    end
                    if (d_cnt == 0) begin
                        bus.dmem_ack = 1'b1;
                        if (bus.dmem_wr) begin
                            mem_ram[bus.dmem_addr] = bus.dmem_wdata;
                            wq.push_back('{a: bus.dmem_addr, d: bus.dmem_wdata});
                        end else begin
                            bus.dmem_rdata = mem_ram[bus.dmem_addr];
                            rq.push_back(bus.dmem_addr);
                        end
                        d_busy = 1'b0;
                    end else begin
                        bus.dmem_ack   = 1'b0;
                        bus.dmem_rdata = WIDTH'($urandom);
                        d_cnt--;
                    end
                end else begin
                    d_busy         = 1'b0;
                    bus.dmem_ack   = spur && ($urandom_range(0, 3) == 0);
                    bus.dmem_rdata = WIDTH'($urandom);
                end

                if (chk_en && retired) begin
                    model_step();
                    n_ret++;
                    ret_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic hold_reset();
        chk_en = 1'b0;
        reset  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_a", a_reg, 0);
        chk("rst_d", d_reg, 0);
        chk("rst_retired", retired, 0);
        chk("rst_halted", halted, 0);
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_dmem_rd", bus.dmem_rd, 0);
        chk("rst_dmem_wr", bus.dmem_wr, 0);
        m_pc      = '0;
        m_a       = '0;
        m_d       = '0;
        m_halted  = 1'b0;
        n_ret     = 0;
        first_req = -1;
        ret_cyc.delete();
        wq.delete();
        rq.delete();
    endtask

    task automatic release_reset();
        reset  = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("idle_no_req", bus.imem_req, 0);
        @(negedge clk);
        chk("first_req", bus.imem_req, 1);
        chk("first_addr", bus.imem_addr, 0);
    endtask

    task automatic run_until(input int n, input int max_cyc);
        int k;
        k = 0;
        while (n_ret < n && !m_halted && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk("run_budget", 64'(n_ret >= n || m_halted), 64'd1);
    endtask

    task automatic check_lat(input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk("ret_count", 64'(ret_cyc.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < ret_cyc.size(); i++)
            chk($sformatf("latency%0d", i), 64'(ret_cyc[i] - first_req), 64'(e[i]));
    endtask

    initial begin
        int k;
        reset = 1'b0;
        chk_en = 1'b0;
        spur = 1'b0;
        i_fixed = 0;
        d_fixed = 0;
        n_chk = 0;
        n_bad = 0;
        cyc = 0;
        first_req = -1;
        bus.imem_ack = 1'b0;
        bus.imem_data = '0;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = '0;
        for (int i = 0; i < RAM_N; i++) begin
            mem_ram[i] = WIDTH'($urandom);
            m_ram[i]   = mem_ram[i];
        end

        // @5; D=A; @7; M=D with zero-wait memory
        clear_rom();
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0007; rom[3] = 16'hE308;
        hold_reset();
        release_reset();
        run_until(4, 200);
        chk("t1_a", a_reg, 7);
        chk("t1_d", d_reg, 5);
        chk("t1_ram7", mem_ram[7], 5);
        check_lat(2, 4, 6, 9);

        // same program, three wait states on every fetch
        i_fixed = 3;
        hold_reset();
        release_reset();
        run_until(4, 400);
        chk("t2_a", a_reg, 7);
        chk("t2_d", d_reg, 5);
        check_lat(5, 10, 15, 21);
        i_fixed = 0;

        // @3; M=M+1 with all-ones in RAM[3]
        clear_rom();
        rom[0] = 16'h0003; rom[1] = 16'hFDC8;
        mem_ram[3] = '1;
        m_ram[3]   = '1;
        hold_reset();
        release_reset();
        run_until(2, 200);
        chk("t3_ram3", mem_ram[3], 0);

        // D=D-1;JGT, not taken then taken
        clear_rom();
        rom[0] = 16'h0001; rom[1] = 16'hEC10; rom[2] = 16'h000A; rom[3] = 16'hE391;
        hold_reset();
        release_reset();
        run_until(4, 200);
        chk("t4_d", d_reg, 0);
        chk("t4_pc", pc, 4);
        rom[0] = 16'h0002;
        hold_reset();
        release_reset();
        run_until(4, 200);
        chk("t4j_d", d_reg, 1);
        chk("t4j_pc", pc, 10);

        // AM=D;JMP uses the old A for both the write and the jump
        clear_rom();
        rom[0] = 16'h0009; rom[1] = 16'hEC10; rom[2] = 16'h0000; rom[3] = 16'hE32F;
        hold_reset();
        release_reset();
        run_until(4, 200);
        chk("t5_a", a_reg, 9);
        chk("t5_pc", pc, 0);
        chk("t5_ram0", mem_ram[0], 9);

        // jump-to-self: @1 at 0, 0;JMP at 1
        clear_rom();
        rom[0] = 16'h0001; rom[1] = 16'hEA87;
        hold_reset();
        release_reset();
`ifdef HACK_CPU_HALT_EN
        run_until(2, 200);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t6_halted", halted, 1);
            chk("t6_no_req", bus.imem_req, 0);
            @(negedge clk);
        end
`else
        run_until(6, 200);
        chk("t6_pc", pc, 1);
        chk("t6_not_halted", halted, 0);
`endif

        // reset while a write is waiting for its ack
        clear_rom();
        rom[0] = 16'h0007; rom[1] = 16'hE308;
        hold_reset();
        d_fixed = 1000;
        release_reset();
        k = 0;
        while (!bus.dmem_wr && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t7_wr_pending", bus.dmem_wr, 1);
        chk_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t7_wr_drop", bus.dmem_wr, 0);
        chk("t7_pc", pc, 0);
        chk("t7_a", a_reg, 0);
        d_fixed = 0;
        mem_ram[7] = 16'h1234;
        m_ram[7]   = 16'h1234;
        hold_reset();
        release_reset();
        run_until(2, 200);
        chk("t7_ram7", mem_ram[7], 0);

        // random programs, random wait states, stray acks
        spur    = 1'b1;
        i_fixed = -1;
        d_fixed = -1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) rom[i] = rand_ins();
            hold_reset();
            release_reset();
            run_until(150, 4000);
            if (m_halted) begin
                repeat (2) @(negedge clk);
                chk("rand_halted", halted, 1);
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
